// File: rtl/tdm_slot_scheduler_pkg.sv
// Shared state encoding and helpers for the TDM slot scheduler.
package tdm_slot_scheduler_pkg;

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_SCAN     = 2'd1;
  localparam logic [1:0] ST_GRANT    = 2'd2;

  localparam int MAX_REQUESTERS = 64;

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_REQUESTERS-1:0] onehot_from_index(input int unsigned idx);
    return MAX_REQUESTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/tdm_slot_scheduler_wrap_counter.sv
// Down counter over 0..RANGE-1 that wraps from 0 back to RANGE-1.
module wrapping_decrement_counter
  import tdm_slot_scheduler_pkg::*;
#(
  parameter int RANGE       = 4,
  parameter int RESET_VALUE = RANGE - 1,
  parameter int WIDTH       = (RANGE > 1) ? $clog2(RANGE) : 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             decrement,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      count <= WIDTH'(RESET_VALUE);
    else if (decrement)
      count <= (count == '0) ? WIDTH'(RANGE - 1) : count - WIDTH'(1);
  end

endmodule

// File: rtl/tdm_slot_scheduler.sv
// Time-division scheduler granting one shared resource slot by slot.
// Optional TDM_SLOT_SCHEDULER_LOOKAHEAD_EN: jump straight to the next requesting slot.
module tdm_slot_scheduler
  import tdm_slot_scheduler_pkg::*;
#(
  parameter int NUM_REQUESTERS      = 4,
  parameter int NUM_REQUESTERS_LOG2 = $clog2(NUM_REQUESTERS),
  parameter int SLOT_CYCLES         = 8,
  parameter int SLOT_CYCLES_LOG2    = $clog2(SLOT_CYCLES + 1)
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic [NUM_REQUESTERS-1:0]      request,
  output logic [NUM_REQUESTERS-1:0]      grant,
  output logic                           grant_valid,
  output logic [NUM_REQUESTERS_LOG2-1:0] slot_index,
  output logic [SLOT_CYCLES_LOG2-1:0]    dwell_remaining
);

  logic [1:0]                     state;
  logic                           slot_req;
  logic                           grant_exit;
  logic                           start_grant;
  logic [NUM_REQUESTERS_LOG2-1:0] grant_slot;

  assign slot_req    = request[slot_index];
  assign grant_exit  = !enable || !slot_req || (dwell_remaining == SLOT_CYCLES_LOG2'(1));
  assign grant_valid = |grant;

`ifdef TDM_SLOT_SCHEDULER_LOOKAHEAD_EN
  logic                           la_found;
  logic [NUM_REQUESTERS_LOG2-1:0] la_slot;

  function automatic logic [NUM_REQUESTERS_LOG2-1:0] wrap_back(
    input logic [NUM_REQUESTERS_LOG2-1:0] s, input int k);
    int t;
    t = int'(s) - k;
    if (t < 0) t = t + NUM_REQUESTERS;
    return NUM_REQUESTERS_LOG2'(t);
  endfunction

  // Walk from the farthest slot to the nearest so the nearest requester wins.
  always_comb begin
    la_found = 1'b0;
    la_slot  = slot_index;
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      if (request[wrap_back(slot_index, k)]) begin
        la_found = 1'b1;
        la_slot  = wrap_back(slot_index, k);
      end
    end
  end

  assign start_grant = (state == ST_SCAN) && enable && la_found;
  assign grant_slot  = la_slot;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      slot_index <= NUM_REQUESTERS_LOG2'(NUM_REQUESTERS - 1);
    else if (start_grant)
      slot_index <= la_slot;
    else if ((state == ST_GRANT) && grant_exit)
      slot_index <= (slot_index == '0) ? NUM_REQUESTERS_LOG2'(NUM_REQUESTERS - 1)
                                       : slot_index - NUM_REQUESTERS_LOG2'(1);
  end
`else
  logic slot_dec;

  assign start_grant = (state == ST_SCAN) && enable && slot_req;
  assign grant_slot  = slot_index;
  // Idle scan steps every cycle; a finished grant always moves on to the next slot.
  assign slot_dec    = ((state == ST_SCAN) && enable && !slot_req) ||
                       ((state == ST_GRANT) && grant_exit);

  wrapping_decrement_counter #(
    .RANGE       (NUM_REQUESTERS),
    .RESET_VALUE (NUM_REQUESTERS - 1),
    .WIDTH       (NUM_REQUESTERS_LOG2)
  ) u_slot_ptr (
    .clock     (clock),
    .resetn    (resetn),
    .decrement (slot_dec),
    .count     (slot_index)
  );
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state           <= ST_DISABLED;
      grant           <= '0;
      dwell_remaining <= '0;
    end else begin
      case (state)
        ST_DISABLED: if (enable) state <= ST_SCAN;
        ST_SCAN: begin
          if (!enable)
            state <= ST_DISABLED;
          else if (start_grant) begin
            state           <= ST_GRANT;
            grant           <= NUM_REQUESTERS'(onehot_from_index(int'(grant_slot)));
            dwell_remaining <= SLOT_CYCLES_LOG2'(SLOT_CYCLES);
          end
        end
        ST_GRANT: begin
          if (grant_exit) begin
            state           <= enable ? ST_SCAN : ST_DISABLED;
            grant           <= '0;
            dwell_remaining <= '0;
          end else
            dwell_remaining <= dwell_remaining - SLOT_CYCLES_LOG2'(1);
        end
        default: begin
          state           <= ST_DISABLED;
          grant           <= '0;
          dwell_remaining <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Directed scoreboard bench for tdm_slot_scheduler (N=3, SLOT_CYCLES=4).
module tb_tdm_slot_scheduler;

  logic       clock = 1'b0;
  logic       resetn;
  logic       enable;
  logic [2:0] request;
  logic [2:0] grant;
  logic       grant_valid;
  logic [1:0] slot_index;
  logic [2:0] dwell_remaining;

  typedef struct {
    logic [2:0] g;
    logic [1:0] s;
    logic [2:0] d;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  tdm_slot_scheduler #(
    .NUM_REQUESTERS (3),
    .SLOT_CYCLES    (4)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .enable          (enable),
    .request         (request),
    .grant           (grant),
    .grant_valid     (grant_valid),
    .slot_index      (slot_index),
    .dwell_remaining (dwell_remaining)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic rst, input logic en, input logic [2:0] req,
                      input logic [2:0] g, input logic [1:0] s, input logic [2:0] d,
                      input string nm);
    exp_t e;
    @(negedge clock);
    resetn  = rst;
    enable  = en;
    request = req;
    e.g = g; e.s = s; e.d = d; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic check_async_reset(input string nm);
    @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    tests++;
    if (grant !== 3'b000 || grant_valid !== 1'b0 || slot_index !== 2'd2 ||
        dwell_remaining !== 3'd0) begin
      fails++;
      $display("FAIL %s: grant=%b valid=%b slot=%0d dwell=%0d, expected 000/0/2/0",
               nm, grant, grant_valid, slot_index, dwell_remaining);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (grant !== e.g || grant_valid !== (|e.g) || slot_index !== e.s ||
            dwell_remaining !== e.d) begin
          fails++;
          $display("FAIL %s: got grant=%b valid=%b slot=%0d dwell=%0d, expected grant=%b valid=%b slot=%0d dwell=%0d",
                   e.nm, grant, grant_valid, slot_index, dwell_remaining,
                   e.g, |e.g, e.s, e.d);
        end
      end
    end
  end

  initial begin : stimulus
    resetn  = 1'b0;
    enable  = 1'b0;
    request = 3'b000;
    for (int i = 0; i < 3; i++) step(0, 1, 3'b100, 3'b000, 2'd2, 3'd0, "reset_hold");
    step(1, 0, 3'b000, 3'b000, 2'd2, 3'd0, "reset_release");
`ifndef TDM_SLOT_SCHEDULER_LOOKAHEAD_EN
    step(1, 1, 3'b100, 3'b000, 2'd2, 3'd0, "t2_enter_scan");
    step(1, 1, 3'b100, 3'b100, 2'd2, 3'd4, "t2_grant_d4");
    step(1, 1, 3'b100, 3'b100, 2'd2, 3'd3, "t2_grant_d3");
    step(1, 1, 3'b100, 3'b100, 2'd2, 3'd2, "t2_grant_d2");
    step(1, 1, 3'b100, 3'b100, 2'd2, 3'd1, "t2_grant_d1");
    step(1, 1, 3'b100, 3'b000, 2'd1, 3'd0, "t2_quota_exit");
    step(1, 1, 3'b100, 3'b000, 2'd0, 3'd0, "t2_scan_s0");
    step(1, 1, 3'b100, 3'b000, 2'd2, 3'd0, "t2_scan_s2");
    step(1, 1, 3'b100, 3'b100, 2'd2, 3'd4, "t2_regrant_d4");
    step(1, 1, 3'b100, 3'b100, 2'd2, 3'd3, "t5_grant_d3");
    step(1, 0, 3'b100, 3'b000, 2'd1, 3'd0, "t5_disable_exit");
    step(1, 0, 3'b000, 3'b000, 2'd1, 3'd0, "t5_disabled_hold");
    step(1, 1, 3'b000, 3'b000, 2'd1, 3'd0, "t5_reenable");
    step(1, 1, 3'b000, 3'b000, 2'd0, 3'd0, "t3_wrap_s0");
    step(1, 1, 3'b000, 3'b000, 2'd2, 3'd0, "t3_wrap_s2");
    step(1, 1, 3'b000, 3'b000, 2'd1, 3'd0, "t3_wrap_s1");
    step(1, 1, 3'b000, 3'b000, 2'd0, 3'd0, "t3_wrap_s0b");
    step(1, 1, 3'b000, 3'b000, 2'd2, 3'd0, "t3_wrap_s2b");
    step(1, 1, 3'b011, 3'b000, 2'd1, 3'd0, "t4_scan_s1");
    step(1, 1, 3'b011, 3'b010, 2'd1, 3'd4, "t4_grant1_d4");
    step(1, 1, 3'b011, 3'b010, 2'd1, 3'd3, "t4_grant1_d3");
    step(1, 1, 3'b001, 3'b000, 2'd0, 3'd0, "t4_early_release");
    step(1, 1, 3'b001, 3'b001, 2'd0, 3'd4, "t4_grant0_d4");
    step(1, 1, 3'b001, 3'b001, 2'd0, 3'd3, "t4_grant0_d3");
    step(1, 1, 3'b001, 3'b001, 2'd0, 3'd2, "t4_grant0_d2");
    step(1, 1, 3'b001, 3'b001, 2'd0, 3'd1, "t4_grant0_d1");
    step(1, 1, 3'b001, 3'b000, 2'd2, 3'd0, "t4_quota_wrap");
    step(1, 1, 3'b010, 3'b000, 2'd1, 3'd0, "t6_scan_s1");
    step(1, 1, 3'b010, 3'b010, 2'd1, 3'd4, "t6_grant1");
`else
    step(1, 1, 3'b001, 3'b000, 2'd2, 3'd0, "la_enter_scan");
    step(1, 1, 3'b001, 3'b001, 2'd0, 3'd4, "la_jump_s0_d4");
    step(1, 1, 3'b001, 3'b001, 2'd0, 3'd3, "la_grant_d3");
    step(1, 1, 3'b001, 3'b001, 2'd0, 3'd2, "la_grant_d2");
    step(1, 1, 3'b001, 3'b001, 2'd0, 3'd1, "la_grant_d1");
    step(1, 1, 3'b001, 3'b000, 2'd2, 3'd0, "la_quota_wrap");
    step(1, 1, 3'b001, 3'b001, 2'd0, 3'd4, "la_rejump_s0");
    step(1, 1, 3'b000, 3'b000, 2'd2, 3'd0, "la_release");
    step(1, 1, 3'b000, 3'b000, 2'd2, 3'd0, "la_idle_hold");
    step(1, 1, 3'b010, 3'b010, 2'd1, 3'd4, "la_jump_s1");
`endif
    check_async_reset("t6_async_reset_midgrant");
    step(0, 1, 3'b010, 3'b000, 2'd2, 3'd0, "t6_reset_held");
    step(1, 0, 3'b010, 3'b000, 2'd2, 3'd0, "t6_reset_release");
    repeat (2) @(posedge clock);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_slot_scheduler.md
Name: tdm_slot_scheduler

Overview:
Time-division scheduler that shares one resource between NUM_REQUESTERS requesters. A slot pointer walks downward through the requesters and wraps; power-of-2 and non-power-of-2 counts are both supported. A requester whose slot comes up while it is requesting gets the resource for up to SLOT_CYCLES cycles. It sits between the requesting agents and the shared datapath's select/enable.

Parameters:
NUM_REQUESTERS, 4, number of requesters/slots (>=2, any value).
NUM_REQUESTERS_LOG2, CLOG2(NUM_REQUESTERS), width of slot index.
SLOT_CYCLES, 8, maximum consecutive grant cycles per slot (>=1).
SLOT_CYCLES_LOG2, CLOG2(SLOT_CYCLES+1), width of dwell counter.

Ports:
clock  input  1  system clock, all logic on rising edge.
resetn  input  1  asynchronous active-low reset.
enable  input  1  scheduler run enable.
request  input  NUM_REQUESTERS  per-requester request level, bit i = requester i.
grant  output  NUM_REQUESTERS  one-hot registered grant, or all zero.
grant_valid  output  1  OR of grant.
slot_index  output  NUM_REQUESTERS_LOG2  current slot pointer.
dwell_remaining  output  SLOT_CYCLES_LOG2  grant cycles left in current slot, including the current cycle; 0 when not granting.

Behaviour:
- Reset, asynchronous on resetn low, applies immediately, including mid-grant:
  - state=DISABLED, slot_index=NUM_REQUESTERS-1, grant=0, grant_valid=0, dwell_remaining=0.
- States: DISABLED, SCAN, GRANT.
- DISABLED:
  - enable=1 -> SCAN next cycle; slot_index held.
- SCAN (grant=0):
  - enable=0 -> DISABLED; slot held.
  - request[slot_index]=1 -> GRANT next cycle.
    - grant=onehot(slot_index), dwell_remaining=SLOT_CYCLES.
  - Otherwise slot_index decrements; 0 wraps to NUM_REQUESTERS-1. Advances every SCAN cycle, even when request=0.
- GRANT:
  - dwell_remaining decrements by 1 each cycle.
  - Exit at the next edge when any of these holds at the current edge:
    - request[slot_index]=0 (early release), or
    - dwell_remaining=1 (quota exhausted), or
    - enable=0.
  - On exit, grant=0 and dwell_remaining=0 next cycle.
  - Next state is SCAN if enable=1, else DISABLED.
  - slot_index decrements with wrap on exit in every case, so the same requester is never re-granted back-to-back while another slot exists.
- Exit condition priority: enable=0 wins; release and quota both produce the same exit.
- Grant latency: one cycle from the SCAN cycle that samples request[slot_index]=1.
- Request changes on non-current slots are ignored until their slot is reached.
- All outputs are registered. No combinational path from request to grant.

Optional Feature:
TDM_SLOT_SCHEDULER_LOOKAHEAD_EN
- Defined: in SCAN, the block searches request in descending wrap order starting at slot_index. It loads slot_index with the first requesting slot and enters GRANT in the same edge, giving single-cycle grant latency regardless of idle slots. With request=0, slot_index holds.
- Undefined: one slot examined per SCAN cycle, as described above.
- GRANT-state behaviour is identical in both builds.

Decomposition:
- Shared package/header: state encoding constants (DISABLED=2'd0, SCAN=2'd1, GRANT=2'd2) and a one-hot-from-index helper function.
- Slot pointer is one instance of the existing wrapping_decrement_counter.
  - RANGE=NUM_REQUESTERS, RESET_VALUE=NUM_REQUESTERS-1.
  - decrement driven by the FSM.
  - Lookahead build replaces it with a loadable register.
- Dwell counter and FSM stay inline.

Test Plan:
- All tests use N=3, SLOT_CYCLES=4 (base build unless noted).
1. Reset -> grant=000, grant_valid=0, slot_index=2, dwell_remaining=0; hold resetn low 3 cycles, no change.
2. enable=1, request=100 held -> grant=100 for exactly 4 cycles (dwell 4,3,2,1), then grant=000 for 3 cycles (SCAN slots 1,0,2), then grant=100 again.
3. Non-pow2 wrap: enable=1, request=000 -> slot_index sequence 2,1,0,2,1 and grant stays 000.
4. Early release: request=011 from slot 1 -> grant=010. Drop request[1] after 2 cycles -> grant=000 next cycle. slot 0 is then reached and grants 001 for 4 cycles.
5. enable=0 during GRANT with dwell_remaining=3 -> grant=000 next cycle, state DISABLED, slot decremented. Re-enable -> scanning resumes from that slot.
6. Reset mid-grant (grant=010) -> outputs return to reset values asynchronously. With LOOKAHEAD_EN and request=001 at slot 2 -> grant=001 one cycle after entering SCAN, slot_index=0.
